// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// axi_sram_slave : AXI3 slave responder over a word-addressed on-chip RAM.
// Rev 1.0 - independent read/write channels, one transaction outstanding each.
// ============================================================================
module axi_sram_slave #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          READ_DELAY = 0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [1:0] c_OKAY     = 2'b00;
  localparam logic [1:0] c_SLVERR   = 2'b10;
  localparam logic [1:0] c_DECERR   = 2'b11;
  localparam logic [1:0] c_FIXED    = 2'b00;
  localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_DLY_LAST = 4'(READ_DELAY - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [31:0] r_mem [c_DEPTH];

  function automatic logic [1:0] f_resp(input logic [31:0] addr, input logic [2:0] size,
                                        input logic [7:0] len);
    if (((addr - BASE_ADDR) >> (DEPTH_LOG2 + 2)) != 32'd0) f_resp = c_DECERR;
    else if (size > 3'd2 || len > 8'd15)                   f_resp = c_SLVERR;
    else                                                   f_resp = c_OKAY;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] f_idx(input logic [31:0] addr);
    f_idx = DEPTH_LOG2'((addr - BASE_ADDR) >> 2);
  endfunction

  // WRAP is deliberately advanced like INCR.
  function automatic logic [31:0] f_next(input logic [31:0] addr, input logic [2:0] size,
                                         input logic [1:0] burst);
    f_next = (burst == c_FIXED) ? addr : addr + (32'd1 << size);
  endfunction

  function automatic logic [1:0] f_worst(input logic [1:0] a, input logic [1:0] b);
    f_worst = (a > b) ? a : b;
  endfunction

  logic w_unused;
  assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // Holds the address channels off until the first edge after reset release.
  logic r_live;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // ---------------------------------------------------------------- read side
  rstate_t     r_rstate, w_rstate_nxt;
  logic [3:0]  r_rid, r_rwait;
  logic [31:0] r_raddr, r_rdata;
  logic [7:0]  r_rlen, r_rbeat;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst, r_rresp;
  logic        r_rlast;

  logic        w_ar_hs, w_r_load;
  logic [31:0] w_r_addr_inc, w_r_addr_n;
  logic [7:0]  w_r_len_n, w_r_beat_n;
  logic [2:0]  w_r_size_n;
  logic [1:0]  w_r_resp_n;

  assign arready = r_live & (r_rstate == R_IDLE);
  assign rvalid  = (r_rstate == R_DATA);
  assign rlast   = rvalid & r_rlast;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign w_ar_hs = arvalid & arready;

  assign w_r_addr_inc = f_next(r_raddr, r_rsize, r_rburst);
  assign w_r_addr_n   = (r_rstate == R_IDLE) ? araddr :
                        (r_rstate == R_WAIT) ? r_raddr : w_r_addr_inc;
  assign w_r_size_n   = (r_rstate == R_IDLE) ? arsize : r_rsize;
  assign w_r_len_n    = (r_rstate == R_IDLE) ? arlen  : r_rlen;
  assign w_r_beat_n   = (r_rstate == R_DATA) ? r_rbeat + 8'd1 : 8'd0;
  assign w_r_resp_n   = f_resp(w_r_addr_n, w_r_size_n, w_r_len_n);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_r_load     = 1'b0;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) begin
        if (READ_DELAY > 0) begin
          w_rstate_nxt = R_WAIT;
        end else begin
          w_rstate_nxt = R_DATA;
          w_r_load     = 1'b1;
        end
      end
      R_WAIT: if (r_rwait == c_DLY_LAST) begin
        w_rstate_nxt = R_DATA;
        w_r_load     = 1'b1;
      end
      R_DATA: if (rready) begin
        if (r_rlast) w_rstate_nxt = R_IDLE;
        else         w_r_load     = 1'b1;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Beat data is captured when the beat is launched, so it cannot change during a stall.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rid    <= 4'd0;
      r_raddr  <= 32'd0;
      r_rlen   <= 8'd0;
      r_rsize  <= 3'd0;
      r_rburst <= 2'd0;
      r_rbeat  <= 8'd0;
      r_rwait  <= 4'd0;
      r_rdata  <= 32'd0;
      r_rresp  <= c_OKAY;
      r_rlast  <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_rid    <= arid;
        r_raddr  <= araddr;
        r_rlen   <= arlen;
        r_rsize  <= arsize;
        r_rburst <= arburst;
        r_rbeat  <= 8'd0;
      end else if (r_rstate == R_DATA && rready && !r_rlast) begin
        r_raddr <= w_r_addr_inc;
        r_rbeat <= r_rbeat + 8'd1;
      end
      if (w_r_load) begin
        r_rdata <= (w_r_resp_n == c_OKAY) ? r_mem[f_idx(w_r_addr_n)] : 32'd0;
        r_rresp <= w_r_resp_n;
        r_rlast <= (w_r_beat_n == w_r_len_n);
      end
      r_rwait <= (r_rstate == R_WAIT) ? r_rwait + 4'd1 : 4'd0;
    end
  end

  // --------------------------------------------------------------- write side
  wstate_t     r_wstate, w_wstate_nxt;
  logic [3:0]  r_bid;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen, r_wbeat;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst, r_bresp;

  logic        w_aw_hs, w_w_hs;
  logic [1:0]  w_w_resp, w_w_len_err;

  assign awready     = r_live & (r_wstate == W_IDLE);
  assign wready      = (r_wstate == W_DATA);
  assign bvalid      = (r_wstate == W_RESP);
  assign bid         = r_bid;
  assign bresp       = r_bresp;
  assign w_aw_hs     = awvalid & awready;
  assign w_w_hs      = wvalid & wready;
  assign w_w_resp    = f_resp(r_waddr, r_wsize, r_wlen);
  assign w_w_len_err = (wlast && r_wbeat != r_wlen) ? c_SLVERR : c_OKAY;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs)          w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && wlast)  w_wstate_nxt = W_RESP;
      W_RESP:  if (bready)           w_wstate_nxt = W_IDLE;
      default:                       w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_bid    <= 4'd0;
      r_waddr  <= 32'd0;
      r_wlen   <= 8'd0;
      r_wsize  <= 3'd0;
      r_wburst <= 2'd0;
      r_wbeat  <= 8'd0;
      r_bresp  <= c_OKAY;
    end else if (w_aw_hs) begin
      r_bid    <= awid;
      r_waddr  <= awaddr;
      r_wlen   <= awlen;
      r_wsize  <= awsize;
      r_wburst <= awburst;
      r_wbeat  <= 8'd0;
      r_bresp  <= c_OKAY;
    end else if (w_w_hs) begin
      r_waddr <= f_next(r_waddr, r_wsize, r_wburst);
      r_wbeat <= r_wbeat + 8'd1;
      r_bresp <= f_worst(r_bresp, f_worst(w_w_resp, w_w_len_err));
    end
  end

  always_ff @(posedge aclk) begin
    if (w_w_hs && w_w_resp == c_OKAY) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// Testbench for axi_sram_slave: directed AXI traffic checked against a memory model and scoreboard.
module tb_axi_sram_slave;

  logic        aclk, areset;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  // Second instance with READ_DELAY=5, read channel only.
  logic [3:0]  d_arid, d_rid, d_bid;
  logic [31:0] d_araddr, d_rdata;
  logic [7:0]  d_arlen;
  logic [2:0]  d_arsize;
  logic [1:0]  d_arburst, d_rresp, d_bresp;
  logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic        d_awready, d_wready, d_bvalid;

  axi_sram_slave #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0), .READ_DELAY(0)) u_dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'd0), .arcache(4'd0), .arprot(3'd0), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'd0), .awcache(4'd0), .awprot(3'd0), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_sram_slave #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0), .READ_DELAY(5)) u_dut_dly (
    .aclk(aclk), .areset(areset),
    .arid(d_arid), .araddr(d_araddr), .arlen(d_arlen), .arsize(d_arsize), .arburst(d_arburst),
    .arlock(2'd0), .arcache(4'd0), .arprot(3'd0), .arvalid(d_arvalid), .arready(d_arready),
    .rid(d_rid), .rdata(d_rdata), .rresp(d_rresp), .rlast(d_rlast), .rvalid(d_rvalid),
    .rready(d_rready),
    .awid(4'd0), .awaddr(32'd0), .awlen(8'd0), .awsize(3'd0), .awburst(2'd0),
    .awlock(2'd0), .awcache(4'd0), .awprot(3'd0), .awvalid(1'b0), .awready(d_awready),
    .wid(4'd0), .wdata(32'd0), .wstrb(4'd0), .wlast(1'b0), .wvalid(1'b0), .wready(d_wready),
    .bid(d_bid), .bresp(d_bresp), .bvalid(d_bvalid), .bready(1'b1)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] mdl[int];
  logic [31:0] wd[16];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM covers byte addresses 0x0000..0x3FFF.
  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] size,
                                          input logic [7:0] len);
    if (a >= 32'h4000)              return 2'b11;
    if (size > 3'd2 || len > 8'd15) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] a, input logic [2:0] size,
                                      input logic [1:0] burst);
    if (burst == 2'b00) return a;
    return a + (32'd1 << size);
  endfunction

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [3:0] strb, input int nbeats);
    logic [31:0] a, w;
    logic [1:0]  worst, br;
    bexp_t       e;
    int          n;
    a = addr;
    worst = 2'b00;
    for (int b = 0; b < nbeats; b++) begin
      br = exp_resp(a, size, len);
      if (br == 2'b00) begin
        w = mdl.exists(int'(a >> 2)) ? mdl[int'(a >> 2)] : 32'd0;
        for (int k = 0; k < 4; k++) if (strb[k]) w[8*k +: 8] = wd[b][8*k +: 8];
        mdl[int'(a >> 2)] = w;
      end
      if (b == nbeats - 1 && b != int'(len) && br < 2'b10) br = 2'b10;
      if (br > worst) worst = br;
      a = adv(a, size, burst);
    end
    bq.push_back('{id: id, resp: worst});

    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    check("aw_accept", 32'(n < 50), 32'd1);
    @(posedge aclk);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge aclk);
      awvalid = 1'b0;
      wvalid  = 1'b1; wdata = wd[b]; wstrb = strb; wlast = (b == nbeats - 1);
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      check("w_accept", 32'(n < 50), 32'd1);
    end
    n = 0;
    do begin
      @(negedge aclk);
      wvalid = 1'b0; wlast = 1'b0;
      n++;
    end while (!bvalid && n < 50);
    check("b_valid", 32'(bvalid), 32'd1);
    e = bq.pop_front();
    check("bid", 32'(bid), 32'(e.id));
    check("bresp", 32'(bresp), 32'(e.resp));
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    logic [31:0] a;
    logic [1:0]  r;
    rbeat_t      e, saved;
    int          n, beats, cyc;
    bit          stalled;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      r = exp_resp(a, size, len);
      e.data = (r == 2'b00) ? mdl[int'(a >> 2)] : 32'd0;
      e.resp = r;
      e.last = (b == int'(len));
      e.id   = id;
      rq.push_back(e);
      a = adv(a, size, burst);
    end

    @(negedge aclk);
    rready = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    check("ar_accept", 32'(n < 50), 32'd1);
    @(posedge aclk);

    beats = 0; cyc = 0; stalled = 1'b0; saved = '0;
    while (beats <= int'(len) && cyc < 200) begin
      @(negedge aclk);
      cyc++;
      arvalid = 1'b0;
      rready  = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (stalled && rvalid) check("r_stall_stable", {rdata[27:0], rresp, rlast, 1'b0} ^ {28'd0, rid},
                                   {saved.data[27:0], saved.resp, saved.last, 1'b0} ^ {28'd0, saved.id});
      if (rvalid && rready) begin
        e = rq.pop_front();
        check("rdata", rdata, e.data);
        check("rid", 32'(rid), 32'(e.id));
        check("rresp", 32'(rresp), 32'(e.resp));
        check("rlast", 32'(rlast), 32'(e.last));
        beats++;
        stalled = 1'b0;
      end else if (rvalid) begin
        saved   = '{data: rdata, resp: rresp, last: rlast, id: rid};
        stalled = 1'b1;
      end
    end
    check("r_burst_complete", 32'(beats), 32'(int'(len) + 1));
  endtask

  initial begin
    int n;
    areset  = 1'b1;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 1'b1;
    d_arid = 0; d_araddr = 0; d_arlen = 0; d_arsize = 0; d_arburst = 0; d_arvalid = 0; d_rready = 0;

    repeat (3) @(negedge aclk);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_ids",     32'({rid, bid}), 32'd0);
    check("rst_resps",   32'({rresp, bresp}), 32'd0);
    check("rst_rdata",   rdata, 32'd0);
    areset = 1'b0;
    #1 check("rel_arready_before_edge", 32'(arready), 32'd0);
    @(negedge aclk);
    check("rel_arready", 32'(arready), 32'd1);
    check("rel_awready", 32'(awready), 32'd1);
    check("idle_wready", 32'(wready),  32'd0);

    // Single write/read
    wd[0] = 32'hDEADBEEF;
    write_burst(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 4'hF, 1);
    read_burst(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);

    // INCR burst with stalling rready
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    write_burst(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, 4'hF, 4);
    read_burst(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1);
    read_burst(4'd8, 32'h100, 8'd3, 3'd2, 2'b10, 1'b0);

    // Byte strobes: expected readback 0x11BB33DD
    wd[0] = 32'h11223344;
    write_burst(4'd4, 32'h20, 8'd0, 3'd2, 2'b01, 4'hF, 1);
    wd[0] = 32'hAABBCCDD;
    write_burst(4'd4, 32'h20, 8'd0, 3'd2, 2'b01, 4'b0101, 1);
    read_burst(4'd4, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0);
    check("strobe_direct", rdata, 32'h11BB33DD);

    // Error responses
    read_burst(4'd5, 32'h4000, 8'd0, 3'd2, 2'b01, 1'b0);
    wd[0] = 32'hFFFFFFFF;
    write_burst(4'd6, 32'h10, 8'd0, 3'd3, 2'b01, 4'hF, 1);
    read_burst(4'd6, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    wd[0] = 32'h50; wd[1] = 32'h51;
    write_burst(4'd7, 32'h200, 8'd3, 3'd2, 2'b01, 4'hF, 2);
    read_burst(4'd9, 32'h100, 8'd16, 3'd2, 2'b01, 1'b0);

    // FIXED burst between two guard words
    wd[0] = 32'hA5A5A5A5;
    write_burst(4'd9, 32'h3C, 8'd0, 3'd2, 2'b01, 4'hF, 1);
    wd[0] = 32'h5A5A5A5A;
    write_burst(4'd9, 32'h44, 8'd0, 3'd2, 2'b01, 4'hF, 1);
    wd[0] = 32'd7; wd[1] = 32'd8; wd[2] = 32'd9;
    write_burst(4'd9, 32'h40, 8'd2, 3'd2, 2'b00, 4'hF, 3);
    read_burst(4'd9, 32'h3C, 8'd2, 3'd2, 2'b01, 1'b0);

    // READ_DELAY=5: rvalid appears in the 6th cycle after the AR handshake
    @(negedge aclk);
    d_arid = 4'hA; d_araddr = 32'h0; d_arlen = 8'd0; d_arsize = 3'd2; d_arburst = 2'b01;
    d_arvalid = 1'b1;
    n = 0;
    while (!d_arready && n < 50) begin @(negedge aclk); n++; end
    check("dly_ar_accept", 32'(n < 50), 32'd1);
    @(posedge aclk);
    n = 0;
    do begin
      @(negedge aclk);
      d_arvalid = 1'b0;
      n++;
    end while (!d_rvalid && n < 20);
    check("dly_first_rvalid_cycle", 32'(n), 32'd6);
    check("dly_rid",   32'(d_rid),   32'hA);
    check("dly_rlast", 32'(d_rlast), 32'd1);
    check("dly_rresp", 32'(d_rresp), 32'd0);
    d_rready = 1'b1;
    @(negedge aclk);
    d_rready = 1'b0;
    check("dly_done", 32'(d_rvalid), 32'd0);

    // Reset during beat 2 of a 4-beat read
    @(negedge aclk);
    araddr = 32'h100; arid = 4'd5; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    check("rst_ar_accept", 32'(n < 50), 32'd1);
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1;
    check("rst_beat1", rdata, 32'd1);
    @(negedge aclk);
    check("rst_beat2_valid", 32'(rvalid), 32'd1);
    check("rst_beat2", rdata, 32'd2);
    areset = 1'b1;
    #1 check("rst_rvalid_drop", 32'(rvalid), 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    #1 check("rst_arready_held", 32'(arready), 32'd0);
    @(negedge aclk);
    check("rst_arready_back", 32'(arready), 32'd1);
    n = 0;
    repeat (4) begin @(negedge aclk); if (rvalid) n++; end
    check("rst_no_more_beats", 32'(n), 32'd0);
    read_burst(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 slave responder backed by an on-chip word-addressed RAM array.
- It is the memory-side counterpart of the CPU's AXI master port. It answers AR/R and AW/W/B traffic from the sram-to-AXI bridge in simulation and FPGA test SoCs.
- Read and write channels run as independent state machines, each with one transaction outstanding.
- A programmable read delay lets the bench stress the master's handshake logic.

Parameters:
- DEPTH_LOG2, 12, log2 of RAM depth in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to 4*2^DEPTH_LOG2).
- READ_DELAY, 0, idle cycles inserted between AR handshake and first R beat (0..15).

Ports:
- aclk  in  1  clock, all state on rising edge.
- areset  in  1  asynchronous, active-high reset.
- arid  in  4  read ID.
- araddr  in  32  read start byte address.
- arlen  in  8  beats-1 (0..15 legal).
- arsize  in  3  bytes per beat = 2^arsize.
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- arlock/arcache/arprot  in  2/4/3  ignored.
- arvalid  in  1  AR valid.
- arready  out  1  AR ready.
- rid  out  4  returned ID.
- rdata  out  32  read data.
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- rlast  out  1  final beat.
- rvalid  out  1  R valid.
- rready  in  1  R ready.
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  as AR.
- awlock/awcache/awprot  in  2/4/3  ignored.
- awvalid  in  1  AW valid.
- awready  out  1  AW ready.
- wid  in  4  ignored.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wlast  in  1  final write beat.
- wvalid  in  1  W valid.
- wready  out  1  W ready.
- bid  out  4  write response ID.
- bresp  out  2  write response.
- bvalid  out  1  B valid.
- bready  in  1  B ready.

Behaviour:

Reset:
- While areset=1: arready=awready=wready=rvalid=rlast=bvalid=0; rid=bid=0; rresp=bresp=0; rdata=0; both FSMs in IDLE.
- arready/awready rise at the first aclk edge after areset falls.
- RAM contents are not reset.
- Reset mid-burst aborts the burst; no further beats are issued.

Read FSM (R_IDLE, R_WAIT, R_DATA):
- R_IDLE: arready=1. On arvalid&arready, latch id, addr, len, size, burst; beat counter=0.
  - Go to R_WAIT if READ_DELAY>0, else R_DATA.
  - arready drops the next cycle.
- R_WAIT: count READ_DELAY cycles, then go to R_DATA.
- R_DATA: rvalid=1; rdata=mem[word index of current addr]; rlast=(beat==len); rid=latched id.
  - rid/rdata/rresp/rlast stay stable while rvalid&!rready.
  - On rvalid&rready: advance. On the last beat, return to R_IDLE; arready is 1 the following cycle, so at least one dead cycle separates bursts.
- Address advance per beat:
  - INCR and WRAP: addr += 2^size. WRAP is treated as INCR.
  - FIXED: addr unchanged.
  - Word index = (addr-BASE_ADDR)>>2, truncated to DEPTH_LOG2 bits.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1. On the AW handshake, latch the AW fields and move to W_DATA.
- W_DATA: wready=1. On each wvalid&wready, write the bytes of mem[index] whose wstrb bit is set, then advance the address as in reads.
  - On a beat with wlast=1, move to W_RESP.
- W_RESP: bvalid=1, bid=latched awid. Hold until bready, then return to W_IDLE.
- W beats arriving before the AW handshake are not accepted (wready=0 outside W_DATA).

Responses:
- Per-beat address outside [BASE_ADDR, BASE_ADDR+4*2^DEPTH_LOG2): DECERR. Read data for that beat is 0; write bytes are discarded.
- size>2: SLVERR on every beat; no RAM access.
- bresp is the worst response over the burst (DECERR > SLVERR > OKAY).
- wlast at beat!=len: bresp=SLVERR. Beats are consumed until wlast regardless of len.
- arlen/awlen >15: SLVERR. The length is honoured modulo nothing; the count runs to the full len.

Concurrency:
- Read and write channels are fully independent.
- Same-cycle read beat and write beat to the same word: rdata returns the pre-write value. A later beat sees the new data.

Test Plan:
- Single read, READ_DELAY=0: write 32'hDEADBEEF to 0x10 (awlen=0, wstrb=F), then AR araddr=0x10, arid=3 → R beat: rdata=DEADBEEF, rid=3, rlast=1, rresp=00. bid=3 if awid=3.
- INCR burst: write 4 beats 0x100..0x10C data 1,2,3,4, then read arlen=3 with rready toggling 1/0 → beats 1,2,3,4 in order, rlast only on beat 4, fields stable during stalls.
- Byte strobes: preload 0x11223344 at 0x20, write wdata=0xAABBCCDD wstrb=4'b0101 → readback 0x11BB33DD.
- Errors: araddr beyond RAM → rresp=11, rdata=0. awsize=3 → bresp=10, RAM unchanged. wlast on beat 2 of awlen=3 → bresp=10.
- Delay/reset: READ_DELAY=5 → first rvalid exactly 6 cycles after the AR handshake. Assert areset during beat 2 of a 4-beat read → rvalid=0 immediately; arready=1 the cycle after release.
- FIXED burst: awburst=00, awlen=2, data 7,8,9 to 0x40 → mem[0x40]=9, adjacent words unchanged.
